branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
- Parametrised successor to the combinational branch resolver: a direct-mapped branch target buffer with 2-bit saturating counters.
- Predicts next PC at fetch; trains from resolved branch/jump outcomes in EX.
- Raises a registered mispredict/redirect one cycle after resolution.
- Sits between the fetch PC mux and the EX-stage branch resolver.

Parameters:
- XLEN, 32, datapath/PC width.
- ENTRIES, 16, BTB entries; power of two, >= 2; IDXW = log2(ENTRIES).
- CTR_INIT, 2'b01, counter value loaded on reset (weakly not-taken).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_fetchValid  in  1  fetch lookup request
- i_fetchPC  in  XLEN  PC being fetched
- o_predTaken  out  1  predicted taken (combinational)
- o_predPC  out  XLEN  predicted next PC (combinational)
- i_resValid  in  1  EX-stage instruction resolving this cycle
- i_resPC  in  XLEN  PC of resolving instruction
- i_resIsBranch  in  1  conditional branch
- i_resIsJump  in  1  JAL or JALR
- i_resTaken  in  1  actual outcome (branch resolver's take)
- i_resTarget  in  XLEN  actual target when taken
- i_resPredTaken  in  1  prediction carried down pipe
- i_resPredPC  in  XLEN  predicted PC carried down pipe
- o_mispredict  out  1  registered flush request
- o_redirectPC  out  XLEN  registered correct next PC

Behaviour:
- Index = PC[IDXW+1:2]; tag = PC[XLEN-1:IDXW+2].
- Entry fields: valid, tag, target, isJump, ctr[1:0].
- Lookup (combinational):
  - hit = i_fetchValid & valid & tag match.
  - o_predTaken = hit & (isJump | ctr[1]).
  - o_predPC = o_predTaken ? target : i_fetchPC+4; arithmetic is modulo 2^XLEN.
- Update (posedge, only when i_resValid & ~i_rst):
  - Jump: write valid=1, tag, target, isJump=1, ctr=2'b11.
  - Branch hit: ctr increments if taken, decrements if not; saturates at 2'b11 / 2'b00. If taken, target is overwritten.
  - Branch miss:
    - Taken: allocate/replace with ctr=2'b10, isJump=0.
    - Not taken: table unchanged.
  - Non-branch/non-jump with tag hit: entry invalidated (alias cleanup).
- Mispredict evaluation:
  - actualNext = (branch|jump) & i_resTaken ? i_resTarget : i_resPC+4.
  - mispredict = (i_resPredTaken != effective taken) | (i_resPredTaken & i_resPredPC != actualNext).
  - Non-branch with i_resPredTaken=1 counts as a mispredict with redirect i_resPC+4.
- Timing: o_mispredict and o_redirectPC are registered; they are valid the cycle after i_resValid. o_mispredict is a 1-cycle pulse. o_redirectPC holds its last value when o_mispredict=0.
- Simultaneous lookup and update to the same index: lookup sees pre-edge contents; the new entry is visible from the next cycle.
- Reset: all valid=0, all ctr=CTR_INIT, o_mispredict=0, o_redirectPC=0. Reset asserted in the same cycle as i_resValid discards that update and its mispredict.
- X on i_res* while i_resValid=0: no effect.

Optional Feature:
- Macro BPU_STATS_EN.
- Defined:
  - Adds ports o_statResolved (32, out) and o_statMispredicts (32, out).
  - o_statResolved increments on every i_resValid with branch|jump.
  - o_statMispredicts increments on every o_mispredict pulse.
  - Both wrap modulo 2^32; reset to 0.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset, then fetch 0x1000 -> o_predTaken=0, o_predPC=0x1004. Resolve at 0x1000 with predTaken=0 -> o_mispredict=0.
- Resolve BEQ at 0x1000, taken, target 0x1010, predTaken=0:
  - Next cycle: o_mispredict=1, o_redirectPC=0x1010.
  - Fetch 0x1000 then -> predTaken=1, predPC=0x1010 (ctr=10).
- Same BEQ resolved not-taken twice -> ctr 10->01->00. Fetch 0x1000 -> predTaken=0, predPC=0x1004. First not-taken resolution with predTaken=1 -> mispredict, redirect 0x1004.
- JAL at 0x1000, target 0x1080 -> fetch 0x1000 predicts 0x1080. JALR at 0x2000 with predPC 0x1080 vs actual 0x1018 -> mispredict, redirect 0x1018.
- Aliasing with ENTRIES=16: allocate 0x1000, then taken branch at 0x1040 (same index) -> fetch 0x1000 misses, predPC=0x1004. Non-branch at 0x1040 with predTaken=1 -> invalidated, redirect 0x1044.
- i_rst asserted in the cycle of a taken resolve -> o_mispredict stays 0, table empty. With BPU_STATS_EN: counters read 0 after reset, then 3/2 after a 3-resolve, 2-mispredict sequence.

Source files
------------

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters: predicts at fetch, trains from EX.
// Optional macro BPU_STATS_EN adds resolved/mispredict statistics counters.
module branch_predictor_btb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ENTRIES  = 16,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_fetchValid,
    input  logic [XLEN-1:0] i_fetchPC,
    output logic            o_predTaken,
    output logic [XLEN-1:0] o_predPC,
    input  logic            i_resValid,
    input  logic [XLEN-1:0] i_resPC,
    input  logic            i_resIsBranch,
    input  logic            i_resIsJump,
    input  logic            i_resTaken,
    input  logic [XLEN-1:0] i_resTarget,
    input  logic            i_resPredTaken,
    input  logic [XLEN-1:0] i_resPredPC,
    output logic            o_mispredict,
    output logic [XLEN-1:0] o_redirectPC
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]     o_statResolved,
    output logic [31:0]     o_statMispredicts
`endif
);

    localparam int unsigned IDXW = $clog2(ENTRIES);
    localparam int unsigned TAGW = XLEN - IDXW - 2;

    logic [ENTRIES-1:0] valid_q,   valid_d;
    logic [ENTRIES-1:0] is_jump_q, is_jump_d;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [TAGW-1:0]    tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    logic               mispredict_q, mispredict_d;
    logic [XLEN-1:0]    redirect_q,   redirect_d;

    logic [IDXW-1:0]    fetch_idx;
    logic [TAGW-1:0]    fetch_tag;
    logic               fetch_hit;
    logic [IDXW-1:0]    res_idx;
    logic [TAGW-1:0]    res_tag;
    logic               res_hit;
    logic               res_cti;
    logic               eff_taken;
    logic [XLEN-1:0]    actual_next;
    logic               res_mispredict;

    assign fetch_idx = i_fetchPC[IDXW+1:2];
    assign fetch_tag = i_fetchPC[XLEN-1:IDXW+2];
    assign res_idx   = i_resPC[IDXW+1:2];
    assign res_tag   = i_resPC[XLEN-1:IDXW+2];

    // Fetch-side lookup reads only registered table contents
    always_comb begin
        fetch_hit   = i_fetchValid & valid_q[fetch_idx] & (tag_q[fetch_idx] == fetch_tag);
        o_predTaken = fetch_hit & (is_jump_q[fetch_idx] | ctr_q[fetch_idx][1]);
        o_predPC    = o_predTaken ? target_q[fetch_idx] : i_fetchPC + XLEN'(4);
    end

    // Resolution: compare the carried prediction with the real next PC
    always_comb begin
        res_hit        = valid_q[res_idx] & (tag_q[res_idx] == res_tag);
        res_cti        = i_resIsBranch | i_resIsJump;
        eff_taken      = res_cti & i_resTaken;
        actual_next    = eff_taken ? i_resTarget : i_resPC + XLEN'(4);
        res_mispredict = (i_resPredTaken != eff_taken)
                       | (i_resPredTaken & (i_resPredPC != actual_next));
        mispredict_d   = i_resValid & res_mispredict;
        redirect_d     = (i_resValid & res_mispredict) ? actual_next : redirect_q;
    end

    // Table training
    always_comb begin
        valid_d   = valid_q;
        is_jump_d = is_jump_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        if (i_resValid) begin
            if (i_resIsJump) begin
                valid_d[res_idx]   = 1'b1;
                is_jump_d[res_idx] = 1'b1;
                tag_d[res_idx]     = res_tag;
                target_d[res_idx]  = i_resTarget;
                ctr_d[res_idx]     = 2'b11;
            end else if (i_resIsBranch) begin
                if (res_hit) begin
                    if (i_resTaken) begin
                        ctr_d[res_idx]    = (ctr_q[res_idx] == 2'b11) ? 2'b11 : ctr_q[res_idx] + 2'd1;
                        target_d[res_idx] = i_resTarget;
                    end else begin
                        ctr_d[res_idx]    = (ctr_q[res_idx] == 2'b00) ? 2'b00 : ctr_q[res_idx] - 2'd1;
                    end
                end else if (i_resTaken) begin
                    valid_d[res_idx]   = 1'b1;
                    is_jump_d[res_idx] = 1'b0;
                    tag_d[res_idx]     = res_tag;
                    target_d[res_idx]  = i_resTarget;
                    ctr_d[res_idx]     = 2'b10;
                end
            end else if (res_hit) begin
                // A non-control instruction matched: the entry belongs to a stale alias
                valid_d[res_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q      <= '0;
            is_jump_q    <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
            end
        end else begin
            valid_q      <= valid_d;
            is_jump_q    <= is_jump_d;
            tag_q        <= tag_d;
            target_q     <= target_d;
            ctr_q        <= ctr_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
        end
    end

    assign o_mispredict = mispredict_q;
    assign o_redirectPC = redirect_q;

`ifdef BPU_STATS_EN
    logic [31:0] stat_resolved_q, stat_resolved_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Mispredict count advances with the edge that raises the pulse
    always_comb begin
        stat_resolved_d    = stat_resolved_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (i_resValid & res_cti) begin
            stat_resolved_d = stat_resolved_q + 32'd1;
        end
        if (mispredict_d) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stat_resolved_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_resolved_q    <= stat_resolved_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign o_statResolved    = stat_resolved_q;
    assign o_statMispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb (ENTRIES=16, XLEN=32); define BPU_STATS_EN to also check the counters.
module tb_branch_predictor_btb;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_fetchValid;
    logic [31:0] i_fetchPC;
    logic        o_predTaken;
    logic [31:0] o_predPC;
    logic        i_resValid;
    logic [31:0] i_resPC;
    logic        i_resIsBranch;
    logic        i_resIsJump;
    logic        i_resTaken;
    logic [31:0] i_resTarget;
    logic        i_resPredTaken;
    logic [31:0] i_resPredPC;
    logic        o_mispredict;
    logic [31:0] o_redirectPC;
`ifdef BPU_STATS_EN
    logic [31:0] o_statResolved;
    logic [31:0] o_statMispredicts;
`endif

    branch_predictor_btb #(.XLEN(32), .ENTRIES(16), .CTR_INIT(2'b01)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_fetchValid   (i_fetchValid),
        .i_fetchPC      (i_fetchPC),
        .o_predTaken    (o_predTaken),
        .o_predPC       (o_predPC),
        .i_resValid     (i_resValid),
        .i_resPC        (i_resPC),
        .i_resIsBranch  (i_resIsBranch),
        .i_resIsJump    (i_resIsJump),
        .i_resTaken     (i_resTaken),
        .i_resTarget    (i_resTarget),
        .i_resPredTaken (i_resPredTaken),
        .i_resPredPC    (i_resPredPC),
        .o_mispredict   (o_mispredict),
        .o_redirectPC   (o_redirectPC)
`ifdef BPU_STATS_EN
        ,
        .o_statResolved    (o_statResolved),
        .o_statMispredicts (o_statMispredicts)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       tag;
        logic        mp;
        logic [31:0] redir;
    } sb_t;

    sb_t         sb_q[$];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] last_redir = 32'h0;
    logic        out_due = 1'b0;
    logic        mon_en  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Registered outputs belong to the resolve accepted at the previous edge
    always @(posedge i_clk) out_due <= i_resValid & ~i_rst;

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (out_due) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check({e.tag, "_mp"}, {31'd0, o_mispredict}, {31'd0, e.mp});
                    check({e.tag, "_redir"}, o_redirectPC, e.redir);
                end
            end else begin
                check("idle_mp", {31'd0, o_mispredict}, 32'd0);
            end
        end
    end

    task automatic step();
        @(negedge i_clk);
        i_resValid     = 1'b0;
        i_resPC        = $urandom;
        i_resIsBranch  = 1'($urandom);
        i_resIsJump    = 1'($urandom);
        i_resTaken     = 1'($urandom);
        i_resTarget    = $urandom;
        i_resPredTaken = 1'($urandom);
        i_resPredPC    = $urandom;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        last_redir = 32'h0;
    endtask

    task automatic drive_res(input logic [31:0] pc, input logic br, input logic jmp, input logic tk,
                             input logic [31:0] tgt, input logic pt, input logic [31:0] ppc,
                             input logic exp_mp, input logic [31:0] exp_redir, input string tag);
        sb_t e;
        i_resValid     = 1'b1;
        i_resPC        = pc;
        i_resIsBranch  = br;
        i_resIsJump    = jmp;
        i_resTaken     = tk;
        i_resTarget    = tgt;
        i_resPredTaken = pt;
        i_resPredPC    = ppc;
        e.tag   = tag;
        e.mp    = exp_mp;
        e.redir = exp_mp ? exp_redir : last_redir;
        last_redir = e.redir;
        sb_q.push_back(e);
    endtask

    task automatic lookup(input logic fv, input logic [31:0] pc, input logic exp_t,
                          input logic [31:0] exp_pc, input string tag);
        i_fetchValid = fv;
        i_fetchPC    = pc;
        #1;
        check({tag, "_taken"}, {31'd0, o_predTaken}, {31'd0, exp_t});
        check({tag, "_pc"}, o_predPC, exp_pc);
        i_fetchValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_fetchValid = 1'b0;
        i_fetchPC    = 32'h0;
        i_resValid   = 1'b0;
        i_resPC = 32'h0; i_resIsBranch = 1'b0; i_resIsJump = 1'b0; i_resTaken = 1'b0;
        i_resTarget = 32'h0; i_resPredTaken = 1'b0; i_resPredPC = 32'h0;
        do_reset();
        mon_en = 1'b1;
        check("rst_mp", {31'd0, o_mispredict}, 32'd0);
        check("rst_redir", o_redirectPC, 32'h0);
        lookup(1'b1, 32'h1000, 1'b0, 32'h1004, "l_empty");

        // Counter training on one BEQ, including both saturation limits
        drive_res(32'h1000, 1, 0, 0, 32'h1010, 0, 32'h1004, 0, 32'h0,    "r_nt_cold"); step();
        lookup(1'b1, 32'h1000, 1'b0, 32'h1004, "l_nt_cold");
        drive_res(32'h1000, 1, 0, 1, 32'h1010, 0, 32'h1004, 1, 32'h1010, "r_beq_t");   step();
        lookup(1'b1, 32'h1000, 1'b1, 32'h1010, "l_beq_t");
        drive_res(32'h1000, 1, 0, 0, 32'h1010, 1, 32'h1010, 1, 32'h1004, "r_beq_nt1"); step();
        lookup(1'b1, 32'h1000, 1'b0, 32'h1004, "l_ctr01");
        drive_res(32'h1000, 1, 0, 0, 32'h1010, 0, 32'h1004, 0, 32'h0,    "r_beq_nt2"); step();
        drive_res(32'h1000, 1, 0, 0, 32'h1010, 0, 32'h1004, 0, 32'h0,    "r_beq_nt3"); step();
        drive_res(32'h1000, 1, 0, 1, 32'h1010, 0, 32'h1004, 1, 32'h1010, "r_beq_t2");  step();
        lookup(1'b1, 32'h1000, 1'b0, 32'h1004, "l_sat_lo");
        drive_res(32'h1000, 1, 0, 1, 32'h1010, 0, 32'h1004, 1, 32'h1010, "r_beq_t3");  step();
        lookup(1'b1, 32'h1000, 1'b1, 32'h1010, "l_ctr10");
        drive_res(32'h1000, 1, 0, 1, 32'h1010, 1, 32'h1010, 0, 32'h0,    "r_beq_t4");  step();
        drive_res(32'h1000, 1, 0, 1, 32'h1010, 1, 32'h1010, 0, 32'h0,    "r_beq_t5");  step();
        drive_res(32'h1000, 1, 0, 0, 32'h1010, 1, 32'h1010, 1, 32'h1004, "r_beq_nt4"); step();
        lookup(1'b1, 32'h1000, 1'b1, 32'h1010, "l_sat_hi");
        drive_res(32'h1000, 1, 0, 1, 32'h1020, 1, 32'h1010, 1, 32'h1020, "r_tgt_new"); step();
        lookup(1'b1, 32'h1000, 1'b1, 32'h1020, "l_tgt_new");

        // Jumps: JAL install, then JALR at an aliasing index replaces it
        drive_res(32'h1000, 0, 1, 1, 32'h1080, 1, 32'h1020, 1, 32'h1080, "r_jal");  step();
        lookup(1'b1, 32'h1000, 1'b1, 32'h1080, "l_jal");
        drive_res(32'h2000, 0, 1, 1, 32'h1018, 1, 32'h1080, 1, 32'h1018, "r_jalr"); step();
        lookup(1'b1, 32'h2000, 1'b1, 32'h1018, "l_jalr");
        lookup(1'b1, 32'h1000, 1'b0, 32'h1004, "l_jal_evict");
        lookup(1'b0, 32'h2000, 1'b0, 32'h2004, "l_fv0");
        drive_res(32'h1104, 0, 0, 0, 32'h0, 0, 32'h1108, 0, 32'h0, "r_alu_ok"); step();

        // Aliasing and alias cleanup
        do_reset();
        drive_res(32'h1000, 1, 0, 1, 32'h1010, 0, 32'h1004, 1, 32'h1010, "r_alias_a"); step();
        drive_res(32'h1040, 1, 0, 1, 32'h1100, 0, 32'h1044, 1, 32'h1100, "r_alias_b"); step();
        lookup(1'b1, 32'h1000, 1'b0, 32'h1004, "l_alias_miss");
        lookup(1'b1, 32'h1040, 1'b1, 32'h1100, "l_alias_hit");
        drive_res(32'h1040, 0, 0, 1, 32'h1100, 1, 32'h1100, 1, 32'h1044, "r_alias_inv"); step();
        lookup(1'b1, 32'h1040, 1'b0, 32'h1044, "l_alias_inv");

        // Same-cycle lookup and update: lookup sees the pre-edge table
        drive_res(32'h3000, 1, 0, 1, 32'h3300, 0, 32'h3004, 1, 32'h3300, "r_same_idx");
        lookup(1'b1, 32'h3000, 1'b0, 32'h3004, "l_pre_edge");
        step();
        lookup(1'b1, 32'h3000, 1'b1, 32'h3300, "l_post_edge");

        // Reset in the cycle of a taken resolve discards it
        i_rst = 1'b1;
        i_resValid = 1'b1; i_resPC = 32'h5000; i_resIsBranch = 1'b1; i_resIsJump = 1'b0;
        i_resTaken = 1'b1; i_resTarget = 32'h5500; i_resPredTaken = 1'b0; i_resPredPC = 32'h5004;
        step();
        i_rst = 1'b0;
        last_redir = 32'h0;
        check("rstres_mp", {31'd0, o_mispredict}, 32'd0);
        check("rstres_redir", o_redirectPC, 32'h0);
        lookup(1'b1, 32'h3000, 1'b0, 32'h3004, "l_rst_empty");
        lookup(1'b1, 32'h5000, 1'b0, 32'h5004, "l_rst_discard");
`ifdef BPU_STATS_EN
        check("stat_res_rst", o_statResolved, 32'd0);
        check("stat_mp_rst", o_statMispredicts, 32'd0);
`endif
        drive_res(32'h5000, 1, 0, 1, 32'h5500, 0, 32'h5004, 1, 32'h5500, "r_st1"); step();
        drive_res(32'h5000, 1, 0, 1, 32'h5500, 1, 32'h5500, 0, 32'h0,    "r_st2"); step();
        drive_res(32'h6004, 0, 1, 1, 32'h6100, 0, 32'h6008, 1, 32'h6100, "r_st3"); step();
        drive_res(32'h7008, 0, 0, 0, 32'h0,    0, 32'h700c, 0, 32'h0,    "r_st4"); step();
`ifdef BPU_STATS_EN
        check("stat_res", o_statResolved, 32'd3);
        check("stat_mp", o_statMispredicts, 32'd2);
`endif

        // PC+4 wraps modulo 2^32
        lookup(1'b1, 32'hffff_fffc, 1'b0, 32'h0, "l_wrap");
        drive_res(32'hffff_fffc, 0, 0, 0, 32'h0, 1, 32'h0, 1, 32'h0, "r_wrap"); step();
        step();
        step();
        check("sb_drain", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
